multicycle_control_fsm: RTL and testbench

//  Multi-cycle RISC-V (RV32I subset) control sequencer. Steps one shared ALU and one unified memory through

---
 rtl/multicycle_control_fsm.sv | 276 +++++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: per-state datapath selects, memory handshake, traps.
// Optional retire counter (instret) when MCCTRL_RETIRE_CNT_EN is defined.
module multicycle_control_fsm #(
   parameter int MAX_WAIT = 15
`ifdef MCCTRL_RETIRE_CNT_EN
   , parameter int CNT_W = 32
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct75,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic [3:0] alu_control,
   output logic [3:0] state_o,
   output logic       illegal,
   output logic       mem_timeout
`ifdef MCCTRL_RETIRE_CNT_EN
   , output logic [CNT_W-1:0] instret
`endif
);

   localparam logic [3:0] FETCH    = 4'd0;
   localparam logic [3:0] DECODE   = 4'd1;
   localparam logic [3:0] MEMADR   = 4'd2;
   localparam logic [3:0] MEMREAD  = 4'd3;
   localparam logic [3:0] MEMWB    = 4'd4;
   localparam logic [3:0] MEMWRITE = 4'd5;
   localparam logic [3:0] EXECR    = 4'd6;
   localparam logic [3:0] EXECI    = 4'd7;
   localparam logic [3:0] ALUWB    = 4'd8;
   localparam logic [3:0] BEQ      = 4'd9;
   localparam logic [3:0] JAL      = 4'd10;
   localparam logic [3:0] TRAP     = 4'd11;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0101;
   localparam logic [3:0] ALU_SLL = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;

   localparam int WW = $clog2(MAX_WAIT + 1);

   logic [3:0]    state_q, state_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          illegal_q, illegal_d;
   logic          mem_timeout_q, mem_timeout_d;
   logic          in_mem;
   logic          timed_out;
   logic          r_bad;
   logic          i_bad;

   function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic sub);
      logic [3:0] r;
      r = ALU_ADD;
      case (f3)
         3'b000:  r = sub ? ALU_SUB : ALU_ADD;
         3'b111:  r = ALU_AND;
         3'b110:  r = ALU_OR;
         3'b100:  r = ALU_XOR;
         3'b010:  r = ALU_SLT;
         3'b001:  r = ALU_SLL;
         3'b101:  r = ALU_SRL;
         default: r = ALU_ADD;
      endcase
      return r;
   endfunction

   // Illegal funct encodings for register and immediate ALU ops
   always_comb begin
      r_bad = (funct3 == 3'b011) || (funct75 && (funct3 != 3'b000));
      i_bad = (funct3 == 3'b011) || (funct75 && (funct3 == 3'b101));
      in_mem = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
      timed_out = in_mem && !mem_ready && (wait_q == WW'(MAX_WAIT));
   end

   // Next-state, sticky trap flags and memory wait counter
   always_comb begin
      state_d       = state_q;
      illegal_d     = illegal_q;
      mem_timeout_d = mem_timeout_q;
      case (state_q)
         FETCH: if (mem_ready) state_d = DECODE;
         DECODE: begin
            if (op == OP_LW || op == OP_SW)            state_d = MEMADR;
            else if (op == OP_R)                       state_d = EXECR;
            else if (op == OP_I)                       state_d = EXECI;
            else if (op == OP_BR && funct3 == 3'b000)  state_d = BEQ;
            else if (op == OP_JAL)                     state_d = JAL;
            else begin
               state_d   = TRAP;
               illegal_d = 1'b1;
            end
         end
         MEMADR:   state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
         MEMREAD:  if (mem_ready) state_d = MEMWB;
         MEMWB:    state_d = FETCH;
         MEMWRITE: if (mem_ready) state_d = FETCH;
         EXECR: begin
            if (r_bad) begin
               state_d   = TRAP;
               illegal_d = 1'b1;
            end else begin
               state_d = ALUWB;
            end
         end
         EXECI: begin
            if (i_bad) begin
               state_d   = TRAP;
               illegal_d = 1'b1;
            end else begin
               state_d = ALUWB;
            end
         end
         ALUWB:   state_d = FETCH;
         BEQ:     state_d = FETCH;
         JAL:     state_d = ALUWB;
         TRAP:    state_d = TRAP;
         default: state_d = TRAP;
      endcase
      if (timed_out) begin
         state_d       = TRAP;
         mem_timeout_d = 1'b1;
      end
      // Any state change restarts the count, so entry to a memory state sees 0
      if (state_d != state_q)         wait_d = '0;
      else if (in_mem && !mem_ready)  wait_d = wait_q + 1'b1;
      else                            wait_d = wait_q;
   end

   // State, wait counter and trap flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FETCH;
         wait_q        <= '0;
         illegal_q     <= 1'b0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         illegal_q     <= illegal_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   // Per-state datapath controls, forced low while reset is asserted
   always_comb begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      imm_src     = 2'b00;
      alu_control = ALU_ADD;
      case (state_q)
         FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            imm_src   = 2'b10;
         end
         MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            imm_src   = (op == OP_SW) ? 2'b01 : 2'b00;
         end
         MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
         end
         MEMWRITE: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            adr_src   = 1'b1;
         end
         EXECR: begin
            alu_src_a   = 2'b10;
            alu_control = alu_map(funct3, funct75);
         end
         EXECI: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = alu_map(funct3, 1'b0);
         end
         ALUWB: reg_write = 1'b1;
         BEQ: begin
            alu_src_a   = 2'b10;
            alu_control = ALU_SUB;
            pc_write    = zero;
         end
         JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
         end
         default: ;
      endcase
      state_o     = state_q;
      illegal     = illegal_q;
      mem_timeout = mem_timeout_q;
      if (!rst_n) begin
         mem_req     = 1'b0;
         mem_write   = 1'b0;
         adr_src     = 1'b0;
         ir_write    = 1'b0;
         pc_write    = 1'b0;
         reg_write   = 1'b0;
         result_src  = 2'b00;
         alu_src_a   = 2'b00;
         alu_src_b   = 2'b00;
         imm_src     = 2'b00;
         alu_control = 4'b0000;
         state_o     = 4'b0000;
         illegal     = 1'b0;
         mem_timeout = 1'b0;
      end
   end

`ifdef MCCTRL_RETIRE_CNT_EN
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             retire;

   // Count instructions that complete back into FETCH
   always_comb begin
      retire = (state_d == FETCH) &&
               ((state_q == MEMWB) || (state_q == MEMWRITE) ||
                (state_q == ALUWB) || (state_q == BEQ));
      instret_d = retire ? instret_q + 1'b1 : instret_q;
   end

   // Retire counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) instret_q <= '0;
      else        instret_q <= instret_d;
   end

   assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm.
// Each step advances one clock and compares outputs against hand-derived values.
module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct75;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [3:0] alu_control, state_o;
   logic       illegal, mem_timeout;
`ifdef MCCTRL_RETIRE_CNT_EN
   logic [31:0] instret;
`endif

   int n_vec = 0;
   int n_err = 0;

   multicycle_control_fsm #(.MAX_WAIT(15)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
      .funct75(funct75), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
      .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .result_src(result_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .imm_src(imm_src),
      .alu_control(alu_control), .state_o(state_o),
      .illegal(illegal), .mem_timeout(mem_timeout)
`ifdef MCCTRL_RETIRE_CNT_EN
      , .instret(instret)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [6:0] o, input logic [2:0] f3,
                            input logic f7);
      op = o;
      funct3 = f3;
      funct75 = f7;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_state", 32'(state_o), 0);
      chk("rst_req", 32'(mem_req), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      set_instr(7'b0, 3'b0, 1'b0);
      zero = 1'b0;
      mem_ready = 1'b1;
      #2;
      chk("reset_all", {state_o, mem_req, mem_write, ir_write, pc_write,
                        reg_write, illegal, mem_timeout, alu_src_b}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // add x3,x1,x2
      set_instr(7'b0110011, 3'b000, 1'b0);
      #1;
      chk("f_ctrl", {mem_req, adr_src, ir_write, pc_write, result_src,
                     alu_src_b, alu_control}, {1'b1, 1'b0, 1'b1, 1'b1,
                     2'b10, 2'b10, 4'b0000});
      tick();
      chk("add_dec", {state_o, alu_src_a, alu_src_b, imm_src, reg_write},
          {4'd1, 2'b01, 2'b01, 2'b10, 1'b0});
      tick();
      chk("add_ex", {state_o, alu_src_a, alu_src_b, alu_control, reg_write},
          {4'd6, 2'b10, 2'b00, 4'b0000, 1'b0});
      tick();
      chk("add_wb", {state_o, reg_write, result_src}, {4'd8, 1'b1, 2'b00});
      tick();
      chk("add_fetch", 32'(state_o), 0);

      // sub
      set_instr(7'b0110011, 3'b000, 1'b1);
      tick(); tick();
      chk("sub_ex", {state_o, alu_control}, {4'd6, 4'b0001});
      tick(); tick();

      // xori
      set_instr(7'b0010011, 3'b100, 1'b0);
      tick(); tick();
      chk("xori_ex", {state_o, alu_src_b, imm_src, alu_control},
          {4'd7, 2'b01, 2'b00, 4'b0100});
      tick();
      chk("xori_wb", 32'(state_o), 8);
      tick();

      // lw with 3 wait cycles in MEMREAD
      set_instr(7'b0000011, 3'b010, 1'b0);
      tick(); tick();
      chk("lw_adr", {state_o, alu_src_a, alu_src_b, imm_src},
          {4'd2, 2'b10, 2'b01, 2'b00});
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("lw_wait", {state_o, mem_req, adr_src, mem_write},
             {4'd3, 1'b1, 1'b1, 1'b0});
      end
      mem_ready = 1'b1;
      #1;
      chk("lw_rd4", 32'(state_o), 3);
      tick();
      chk("lw_wb", {state_o, result_src, reg_write}, {4'd4, 2'b01, 1'b1});
      tick();
      chk("lw_fetch", 32'(state_o), 0);

      // beq taken / not taken
      set_instr(7'b1100011, 3'b000, 1'b0);
      zero = 1'b1;
      tick(); tick();
      chk("beq_t", {state_o, pc_write, alu_control, alu_src_a, result_src},
          {4'd9, 1'b1, 4'b0001, 2'b10, 2'b00});
      tick();
      chk("beq_t_ret", 32'(state_o), 0);
      zero = 1'b0;
      tick(); tick();
      chk("beq_nt", {state_o, pc_write}, {4'd9, 1'b0});
      tick();
      chk("beq_nt_ret", 32'(state_o), 0);

      // jal
      set_instr(7'b1101111, 3'b000, 1'b0);
      tick(); tick();
      chk("jal", {state_o, pc_write, alu_src_a, alu_src_b, result_src},
          {4'd10, 1'b1, 2'b01, 2'b10, 2'b00});
      tick();
      chk("jal_wb", {state_o, reg_write}, {4'd8, 1'b1});
      tick();

      // memory wait boundary: ready after 15 low cycles completes
      set_instr(7'b0110011, 3'b000, 1'b0);
      mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      chk("wait15_fetch", {state_o, mem_timeout}, {4'd0, 1'b0});
      mem_ready = 1'b1;
      #1;
      chk("wait15_irw", 32'(ir_write), 1);
      tick();
      chk("wait15_dec", 32'(state_o), 1);
      tick(); tick(); tick();
      chk("back_fetch", 32'(state_o), 0);

      // timeout: 16th low cycle traps
      mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      chk("tmo_pre", 32'(state_o), 0);
      tick();
      chk("tmo_trap", {state_o, mem_timeout, illegal}, {4'd11, 1'b1, 1'b0});
      chk("tmo_outs", {mem_req, pc_write, reg_write, ir_write, alu_src_b,
                       result_src}, 0);
      do_reset();
      chk("tmo_clr", {mem_timeout, mem_req}, {1'b0, 1'b1});

      // illegal opcode
      mem_ready = 1'b1;
      set_instr(7'b1110011, 3'b000, 1'b0);
      tick(); tick();
      chk("ill_trap", {state_o, illegal, mem_timeout, mem_req},
          {4'd11, 1'b1, 1'b0, 1'b0});
      tick(); tick();
      chk("ill_stay", {state_o, illegal}, {4'd11, 1'b1});
      do_reset();
      chk("ill_rel", {state_o, mem_req, illegal}, {4'd0, 1'b1, 1'b0});

      // illegal R-type funct: funct75 with sll
      set_instr(7'b0110011, 3'b001, 1'b1);
      tick(); tick(); tick();
      chk("ill_r", {state_o, illegal}, {4'd11, 1'b1});
      do_reset();

      // sw, reset asserted mid-MEMWRITE
      set_instr(7'b0100011, 3'b010, 1'b0);
      tick(); tick();
      chk("sw_adr", {state_o, imm_src}, {4'd2, 2'b01});
      mem_ready = 1'b0;
      tick();
      chk("sw_wr", {state_o, mem_req, mem_write, adr_src},
          {4'd5, 1'b1, 1'b1, 1'b1});
      rst_n = 1'b0;
      #1;
      chk("sw_abort", {state_o, mem_req, mem_write}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("sw_rel", {state_o, mem_req, mem_write}, {4'd0, 1'b1, 1'b0});

`ifdef MCCTRL_RETIRE_CNT_EN
      chk("ir_rst", instret, 0);
      mem_ready = 1'b1;
      set_instr(7'b0110011, 3'b000, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick(); tick(); tick(); tick();
      end
      chk("instret3", instret, 3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
